// File: rtl/io_input_port.sv
// io_input_port: memory-mapped input peripheral for the board push-buttons and DIP switches.
// Buttons and switches go through a 2-flop synchroniser. Each button is then debounced.
// A press event is latched in a sticky flag, which software clears by writing 1 to the bit.
// Loads of the status and event registers return on the stage-3 data path with one-cycle latency.
// On an I/O address this module overrides the memory read data.
// Optional feature: define IO_READ_CLEAR_EN so that a load of the event register clears all flags.
module io_input_port #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int          NUM_BUTTONS     = 2,
  parameter int          NUM_SWITCHES    = 8,
  parameter logic [31:0] STATUS_ADDR     = 32'h7f8,
  parameter logic [31:0] EVENT_ADDR      = 32'h7fc
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_enable,
  input  logic [31:0]             addr,
  input  logic                    write_enable,
  input  logic [31:0]             data_in,
  input  logic [NUM_BUTTONS-1:0]  buttons_n,
  input  logic [NUM_SWITCHES-1:0] switches,
  input  logic [31:0]             mem_data_in,
  output logic [31:0]             data_out,
  output logic                    io_hit_s3
);

  localparam int CNT_W = $clog2(int'(DEBOUNCE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(int'(DEBOUNCE_CYCLES) - 1);

  logic [NUM_BUTTONS-1:0]  btn_meta_q, btn_sync_q;
  logic [NUM_SWITCHES-1:0] sw_meta_q, sw_sync_q;
  logic [NUM_BUTTONS-1:0]  btn_stable_q, btn_stable_d;
  logic [CNT_W-1:0]        cnt_q [NUM_BUTTONS];
  logic [CNT_W-1:0]        cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0]  flags_q, flags_d;
  logic [NUM_BUTTONS-1:0]  pressed, press_rise, clr_mask;
  logic                    io_hit_q, io_hit_d;
  logic [31:0]             rd_latch_q, rd_latch_d;
  logic [31:0]             status_word, event_word;
  logic                    hit_status, hit_event;
  logic                    unused_bits;

  // Byte offset and the store data above the flag bits have no meaning for I/O words.
  assign unused_bits = ^{addr[1:0], data_in[31:NUM_BUTTONS]};

  // Word-granular decode: any byte address within either register word selects it.
  assign hit_status = (addr[31:2] == STATUS_ADDR[31:2]);
  assign hit_event  = (addr[31:2] == EVENT_ADDR[31:2]);

  // Two-flop synchroniser on every raw input bit; runs every clock regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      btn_meta_q <= buttons_n;
      btn_sync_q <= btn_meta_q;
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronised level disagrees with the accepted level.
  always_comb begin
    pressed      = ~btn_sync_q;
    btn_stable_d = btn_stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != btn_stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          btn_stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state register; deliberately not gated by clk_enable so filtering continues during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      btn_stable_q <= btn_stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Event flags: OR-in new presses after applying clears, so a same-cycle press survives a clear.
  always_comb begin
    press_rise = btn_stable_d & ~btn_stable_q;
    clr_mask   = '0;
    if (clk_enable && write_enable && hit_event) begin
      clr_mask = data_in[NUM_BUTTONS-1:0];
    end
`ifdef IO_READ_CLEAR_EN
    if (clk_enable && !write_enable && hit_event) begin
      clr_mask = '1;
    end
`endif
    flags_d = (flags_q & ~clr_mask) | press_rise;
  end

  // Event flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // Read words are built from pre-edge state, so a clearing load still returns the old flags.
  always_comb begin
    status_word = '0;
    status_word[16 +: NUM_SWITCHES] = sw_sync_q;
    status_word[0 +: NUM_BUTTONS]   = btn_stable_q;
    event_word = '0;
    event_word[0 +: NUM_BUTTONS]    = flags_q;
    io_hit_d   = hit_status | hit_event;
    rd_latch_d = hit_status ? status_word : event_word;
  end

  // Stage-3 read latch; holds while the pipeline is stalled, like the memory's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_hit_q   <= 1'b0;
      rd_latch_q <= '0;
    end else if (clk_enable) begin
      io_hit_q   <= io_hit_d;
      rd_latch_q <= rd_latch_d;
    end
  end

  assign io_hit_s3 = io_hit_q;
  assign data_out  = io_hit_q ? rd_latch_q : mem_data_in;

endmodule

// File: tb/tb_io_input_port.sv
// Testbench for io_input_port: directed scenarios followed by randomized traffic.
// Results are compared against a behavioural model of the documented register and debounce rules.
module tb_io_input_port;

  localparam int          NB = 2;
  localparam int          NS = 8;
  localparam logic [15:0] DC = 16'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_enable = 1'b1;
  logic [31:0]   addr = 32'h100;
  logic          write_enable = 1'b0;
  logic [31:0]   data_in = 32'h0;
  logic [NB-1:0] buttons_n = '1;
  logic [NS-1:0] switches = 8'hA5;
  logic [31:0]   mem_data_in = 32'h1234_5678;
  logic [31:0]   data_out;
  logic          io_hit_s3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_input_port #(
    .DEBOUNCE_CYCLES(DC),
    .NUM_BUTTONS(NB),
    .NUM_SWITCHES(NS),
    .STATUS_ADDR(32'h7f8),
    .EVENT_ADDR(32'h7fc)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_enable(clk_enable),
    .addr(addr),
    .write_enable(write_enable),
    .data_in(data_in),
    .buttons_n(buttons_n),
    .switches(switches),
    .mem_data_in(mem_data_in),
    .data_out(data_out),
    .io_hit_s3(io_hit_s3)
  );

  // Behavioural model: delayed raw levels, a run length of disagreeing samples, sticky flags.
  logic [NB-1:0] m_b1, m_b2, m_stable, m_flags;
  logic [NS-1:0] m_s1, m_s2;
  int            m_run [NB];
  logic          m_hit;
  logic [31:0]   m_latch;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [NB-1:0] pressed, next_stable, clr;
    logic          hs, he;
    if (!rst_n) begin
      m_b1 = '0; m_b2 = '0; m_s1 = '0; m_s2 = '0;
      m_stable = '0; m_flags = '0; m_hit = 1'b0; m_latch = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      hs = ((addr & ~32'h3) == 32'h7f8);
      he = ((addr & ~32'h3) == 32'h7fc);
      pressed = ~m_b2;
      next_stable = m_stable;
      for (int i = 0; i < NB; i++) begin
        if (pressed[i] == m_stable[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] >= int'(DC)) begin
            next_stable[i] = pressed[i];
            m_run[i] = 0;
          end
        end
      end
      clr = '0;
      if (clk_enable && write_enable && he) clr = data_in[NB-1:0];
`ifdef IO_READ_CLEAR_EN
      if (clk_enable && !write_enable && he) clr = '1;
`endif
      if (clk_enable) begin
        m_hit = hs || he;
        if (hs) m_latch = (32'(m_s2) << 16) | 32'(m_stable);
        else if (he) m_latch = 32'(m_flags);
      end
      m_flags  = (m_flags & ~clr) | (next_stable & ~m_stable);
      m_stable = next_stable;
      m_b2 = m_b1; m_b1 = buttons_n;
      m_s2 = m_s1; m_s1 = switches;
    end
  endtask

  // One clock: update the model at the rising edge, compare outputs at the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq({tag, "/hit"}, {31'b0, io_hit_s3}, {31'b0, m_hit});
    check_eq({tag, "/dout"}, data_out, m_hit ? m_latch : mem_data_in);
  endtask

  task automatic bus(input logic [31:0] a, input logic we, input logic [31:0] d);
    addr = a;
    write_enable = we;
    data_in = d;
  endtask

  task automatic idle(input int n, input string tag);
    bus(32'h100, 1'b0, 32'h0);
    repeat (n) cycle(tag);
  endtask

  initial begin
    repeat (2) cycle("reset");
    check_eq("reset_dout", data_out, 32'h1234_5678);
    rst_n = 1'b1;
    idle(8, "settle");

    // Reset mid-run with a button held.
    buttons_n = 2'b10;
    bus(32'h7f8, 1'b0, 32'h0);
    repeat (10) cycle("t1_press");
    check_eq("t1_pre_status", data_out, 32'h00A5_0001);
    rst_n = 1'b0;
    cycle("t1_rst");
    check_eq("t1_rst_hit", {31'b0, io_hit_s3}, 32'h0);
    buttons_n = 2'b11;
    cycle("t1_rst2");
    rst_n = 1'b1;
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t1_evt");
    check_eq("t1_flags_zero", data_out, 32'h0);
    idle(8, "t1_wait");
    bus(32'h7f9, 1'b0, 32'h0);
    cycle("t1_status");
    check_eq("t1_btn_released", data_out, 32'h00A5_0000);

    // A 3-cycle glitch must not be accepted.
    buttons_n = 2'b10;
    repeat (3) cycle("t2_glitch");
    buttons_n = 2'b11;
    repeat (8) cycle("t2_after");
    check_eq("t2_glitch_status", data_out, 32'h00A5_0000);
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t2_evt");
    check_eq("t2_glitch_evt", data_out, 32'h0);

    // A held press is accepted and raises its event flag.
    buttons_n = 2'b10;
    bus(32'h7f8, 1'b0, 32'h0);
    repeat (10) cycle("t2_press");
    check_eq("t2_press_status", data_out, 32'h00A5_0001);
    buttons_n = 2'b11;
    idle(8, "t2_release");
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t2_evt2");
    check_eq("t2_press_evt", data_out, 32'h1);

    // Read mux: btn1 held, switches A5.
    buttons_n = 2'b01;
    idle(8, "t4_hold");
    bus(32'h7f8, 1'b0, 32'h0);
    cycle("t4_status");
    check_eq("t4_status_word", data_out, 32'h00A5_0002);
    check_eq("t4_status_hit", {31'b0, io_hit_s3}, 32'h1);
    bus(32'h100, 1'b0, 32'h0);
    mem_data_in = 32'hDEAD_BEEF;
    cycle("t4_mem");
    check_eq("t4_mem_dout", data_out, 32'hDEAD_BEEF);
    check_eq("t4_mem_hit", {31'b0, io_hit_s3}, 32'h0);

    // W1C on bit0 leaves bit1.
    buttons_n = 2'b11;
    idle(8, "t3_release");
    bus(32'h7fc, 1'b1, 32'h1);
    cycle("t3_store");
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t3_load");
    check_eq("t3_w1c", data_out, 32'h2);
    idle(2, "t3_gap");

    // Press on the same edge as a clear of that bit: the press wins.
    buttons_n = 2'b01;
    repeat (5) cycle("t3_press");
    bus(32'h7fc, 1'b1, 32'h2);
    cycle("t3_same_edge");
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t3_load2");
    check_eq("t3_set_wins", data_out, 32'h2);

    // Stall: the loaded event word holds while addr changes.
    clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus($urandom, 1'b0, 32'h0);
      mem_data_in = $urandom;
      cycle("t5_stall");
      check_eq("t5_stall_hold", data_out, 32'h2);
    end
    clk_enable = 1'b1;

    // Read-clear behaviour with flags = 01.
    buttons_n = 2'b11;
    idle(8, "t6_release");
    bus(32'h7fc, 1'b1, 32'h3);
    cycle("t6_clear");
    buttons_n = 2'b10;
    idle(10, "t6_press");
    buttons_n = 2'b11;
    idle(8, "t6_release2");
    bus(32'h7fc, 1'b0, 32'h0);
    cycle("t6_load1");
    check_eq("t6_first_load", data_out, 32'h1);
    cycle("t6_load2");
`ifdef IO_READ_CLEAR_EN
    check_eq("t6_second_load", data_out, 32'h0);
`else
    check_eq("t6_second_load", data_out, 32'h1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      int b;
      if ($urandom_range(0, 9) == 0) begin
        b = int'($urandom_range(0, NB - 1));
        buttons_n[b] = ~buttons_n[b];
      end
      if ($urandom_range(0, 19) == 0) switches = NS'($urandom);
      clk_enable = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 5))
        0, 1:    addr = 32'h7f8 | 32'($urandom_range(0, 3));
        2, 3:    addr = 32'h7fc | 32'($urandom_range(0, 3));
        4:       addr = 32'h100;
        default: addr = $urandom;
      endcase
      write_enable = ($urandom_range(0, 3) == 0);
      data_in = $urandom;
      mem_data_in = $urandom;
      rst_n = !((n % 1000) == 500);
      cycle("rnd");
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
